// File: rtl/req_slave_fifo.sv
// req/ack slave: captures one word per request, acknowledges for a programmable
// number of cycles, and queues captured words in a first-word-fall-through FIFO.
module req_slave_fifo #(
  parameter int DATA_W     = 8,
  parameter int ACK_CYCLES = 2,
  parameter int DEPTH      = 4,
  parameter int FOUR_PHASE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req,
  input  logic [DATA_W-1:0]          data_in,
  output logic                       ack,
  output logic [DATA_W-1:0]          last_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  input  logic                       clr_ovf,
  output logic [1:0]                 state_dbg
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  // Handshake: a word is taken on the edge where req is seen high in S_WAIT;
  // ack rises on that edge and the slave never back-pressures the master.
  // The consumer side pops the head on any edge with rd_en high and empty low.
  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_ACK  = 2'd1,
    S_REL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   last_q, last_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                push, pop, push_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    push    = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (req) begin
          last_d  = data_in;
          push    = 1'b1;
          cnt_d   = 8'(ACK_CYCLES - 1);
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (cnt_q == 8'd0) begin
          if (FOUR_PHASE != 0 && req) state_d = S_REL;
          else                        state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_REL: begin
        if (!req) state_d = S_WAIT;
      end
      default: begin
        state_d = S_WAIT;
        cnt_d   = 8'd0;
      end
    endcase
    // ack is a register that tracks "not waiting" one edge late of the decision
    ack_d = (state_d == S_ACK) || (state_d == S_REL);
  end

  always_comb begin
    pop      = rd_en && (count_q != '0);
    // a pop on the same edge frees the slot for a push into a full FIFO
    push_ok  = push && ((count_q != CNT_W'(DEPTH)) || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (push && !push_ok) ovf_d = 1'b1;
    else if (clr_ovf)     ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_WAIT;
      cnt_q    <= 8'd0;
      ack_q    <= 1'b0;
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= data_in;
  end

  assign ack       = ack_q;
  assign last_data = last_q;
  assign rd_data   = mem_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_req_slave_fifo.sv
// Bench for req_slave_fifo: a legacy-ack instance for FIFO/overflow/reset
// behaviour and a four-phase instance for the held-request case.
module tb_req_slave_fifo;

  localparam int DATA_W = 8;
  localparam int ACKC   = 2;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic              req = 1'b0, rd_en = 1'b0, clr_ovf = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              ack, empty, full, overflow;
  logic [DATA_W-1:0] last_data, rd_data;
  logic [CNT_W-1:0]  count;
  logic [1:0]        state_dbg;

  logic              req2 = 1'b0, rd_en2 = 1'b0, clr_ovf2 = 1'b0;
  logic [DATA_W-1:0] data2 = '0;
  logic              ack2, empty2, full2, overflow2;
  logic [DATA_W-1:0] last2, rd_data2;
  logic [CNT_W-1:0]  count2;
  logic [1:0]        state2;

  int n_chk = 0;
  int n_err = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic m_ovf = 1'b0;

  req_slave_fifo #(.DATA_W(DATA_W), .ACK_CYCLES(ACKC), .DEPTH(DEPTH), .FOUR_PHASE(0)) u_dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .ack(ack),
    .last_data(last_data), .rd_en(rd_en), .rd_data(rd_data), .empty(empty),
    .full(full), .count(count), .overflow(overflow), .clr_ovf(clr_ovf),
    .state_dbg(state_dbg)
  );

  req_slave_fifo #(.DATA_W(DATA_W), .ACK_CYCLES(ACKC), .DEPTH(DEPTH), .FOUR_PHASE(1)) u_dut4p (
    .clk(clk), .rst(rst), .req(req2), .data_in(data2), .ack(ack2),
    .last_data(last2), .rd_en(rd_en2), .rd_data(rd_data2), .empty(empty2),
    .full(full2), .count(count2), .overflow(overflow2), .clr_ovf(clr_ovf2),
    .state_dbg(state2)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    check_eq({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
    check_eq({tag, "_full"}, 32'(full), 32'(exp_q.size() == DEPTH));
    check_eq({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    if (exp_q.size() != 0) check_eq({tag, "_head"}, 32'(rd_data), 32'(exp_q[0]));
  endtask

  // One single-cycle request, optionally with a pop and/or clr_ovf on the capture edge.
  task automatic xfer(input logic [DATA_W-1:0] d, input logic pop, input logic clr);
    int n;
    logic acc;
    logic popped;
    @(negedge clk);
    req = 1'b1; data_in = d; rd_en = pop; clr_ovf = clr;
    popped = pop && (exp_q.size() != 0);
    acc = (exp_q.size() < DEPTH) || popped;
    if (popped) check_eq("xfer_pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
    if (acc) exp_q.push_back(d);
    if (!acc) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(negedge clk);
    req = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
    data_in = DATA_W'($urandom_range(0, 255));
    check_eq("ack_rise", 32'(ack), 32'd1);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ack) break;
      n++;
    end
    check_eq("ack_len", 32'(n), 32'(ACKC));
    check_eq("last_data", 32'(last_data), 32'(d));
    check_status("xfer");
  endtask

  task automatic pop_one();
    @(negedge clk);
    check_eq("pop_empty", 32'(empty), 32'(exp_q.size() == 0));
    if (exp_q.size() != 0) check_eq("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check_status("pop");
  endtask

  initial begin
    bit pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int n;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_last", 32'(last_data), 32'd0);
    check_status("rst");

    // single transfer
    xfer(8'hA5, 1'b0, 1'b0);
    pop_one();

    // fill, overflow on the fifth word, drain in order
    xfer(8'h11, 1'b0, 1'b0);
    xfer(8'h22, 1'b0, 1'b0);
    xfer(8'h33, 1'b0, 1'b0);
    xfer(8'h44, 1'b0, 1'b0);
    xfer(8'h55, 1'b0, 1'b0);
    repeat (4) pop_one();

    // full FIFO: capture with simultaneous pop, then drop racing clr_ovf, then clear
    xfer(8'h11, 1'b0, 1'b0);
    xfer(8'h22, 1'b0, 1'b0);
    xfer(8'h33, 1'b0, 1'b0);
    xfer(8'h44, 1'b0, 1'b0);
    xfer(8'h66, 1'b1, 1'b0);
    xfer(8'h77, 1'b0, 1'b1);
    @(negedge clk);
    clr_ovf = 1'b1;
    m_ovf = 1'b0;
    @(negedge clk);
    clr_ovf = 1'b0;
    check_eq("clr_ovf", 32'(overflow), 32'(m_ovf));
    repeat (4) pop_one();

    // legacy mode with req held: a capture every third edge
    @(negedge clk);
    req = 1'b1;
    for (int k = 0; k < 7; k++) begin
      data_in = DATA_W'(8'h70 + k);
      if (k % 3 == 0) exp_q.push_back(DATA_W'(8'h70 + k));
      @(negedge clk);
      check_eq($sformatf("held_ack%0d", k), 32'(ack), 32'(pat[k]));
    end
    req = 1'b0;
    n = 0;
    while (ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("held_ack_drop", 32'(ack), 32'd0);
    check_eq("held_last", 32'(last_data), 32'h76);
    check_status("held");

    // reset in the second ack cycle with three words queued
    pop_one();
    @(negedge clk);
    req = 1'b1; data_in = 8'h99;
    exp_q.push_back(8'h99);
    @(negedge clk);
    req = 1'b0;
    check_eq("pre_rst_count", 32'(count), 32'd3);
    @(negedge clk);
    check_eq("pre_rst_ack", 32'(ack), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_ovf = 1'b0;
    check_eq("mid_rst_ack", 32'(ack), 32'd0);
    check_eq("mid_rst_last", 32'(last_data), 32'd0);
    check_status("mid_rst");
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check_status("rd_empty");
    @(negedge clk);
    check_eq("idle_ack", 32'(ack), 32'd0);

    // four-phase: req held six edges gives one capture and a stretched ack
    @(negedge clk);
    req2 = 1'b1; data2 = 8'h3C;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      data2 = DATA_W'($urandom_range(0, 255));
      check_eq($sformatf("fp_ack%0d", k), 32'(ack2), 32'd1);
    end
    req2 = 1'b0;
    @(negedge clk);
    check_eq("fp_ack_drop", 32'(ack2), 32'd0);
    @(negedge clk);
    check_eq("fp_ack_stay", 32'(ack2), 32'd0);
    check_eq("fp_count", 32'(count2), 32'd1);
    check_eq("fp_head", 32'(rd_data2), 32'h3C);
    check_eq("fp_last", 32'(last2), 32'h3C);
    check_eq("fp_ovf", 32'(overflow2), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/req_slave_fifo.md
Name: req_slave_fifo

Overview:
Parametrised req/ack slave. It captures one DATA_W-bit word per request and answers with a registered ack lasting a programmable number of cycles. A compile-time mode selects between a legacy fixed-pulse ack and a four-phase ack that waits for req to drop. Captured words are queued in a DEPTH-entry FWFT FIFO for a downstream consumer, so words are kept beyond the single last-word register, with full/empty/count status and sticky overflow.

Parameters:
DATA_W, 8, width of data_in / last_data / rd_data
ACK_CYCLES, 2, minimum cycles ack is held high per transfer; legal range 1..255
DEPTH, 4, FIFO entries; power of 2, minimum 2
FOUR_PHASE, 0, 0 = ack drops after exactly ACK_CYCLES; 1 = ack also held until req sampled low

Ports:
clk  input  1  rising-edge clock, sole clock domain
rst  input  1  synchronous, active-high reset
req  input  1  master request, level
data_in  input  DATA_W  master data, valid while req high
ack  output  1  registered acknowledge
last_data  output  DATA_W  most recently captured word (registered)
rd_en  input  1  pop head of FIFO when high and not empty
rd_data  output  DATA_W  FIFO head (FWFT); undefined/held when empty
empty  output  1  FIFO empty
full  output  1  FIFO full
count  output  clog2(DEPTH+1)  current occupancy
overflow  output  1  sticky: a captured word was dropped
clr_ovf  input  1  clears overflow

Behaviour:
- Reset (rst sampled high): state=S_WAIT, ack=0, last_data=0, FIFO pointers=0, count=0, empty=1, full=0, overflow=0, ack counter=0. Applies mid-transfer: ack low from the cycle after the reset edge; queued words are discarded.
- States: S_WAIT, S_ACK, S_REL (S_REL is used only when FOUR_PHASE=1). Encoding is free; any illegal state returns to S_WAIT with ack=0.
- S_WAIT: on the edge where req=1, last_data<=data_in, issue push, counter<=ACK_CYCLES-1, go S_ACK. ack=1 from that edge (one cycle after req first seen). If req=0, stay in S_WAIT, ack=0.
- S_ACK: ack=1. Counter decrements per cycle. When counter==0:
  - FOUR_PHASE=0: go S_WAIT, ack=0 next cycle. If req is still high in S_WAIT, a new capture occurs (legacy behaviour; the master must drop req within ACK_CYCLES).
  - FOUR_PHASE=1: if req=0, go S_WAIT; else go S_REL.
- S_REL: ack=1. Leave for S_WAIT on the edge where req=0; ack low the next cycle. No capture is possible until S_WAIT sees req=1 again.
- ack is high for exactly ACK_CYCLES cycles per transfer in mode 0, and at least ACK_CYCLES cycles in mode 1.
- data_in is sampled only on the capture edge; changes during ack are ignored.
- FIFO push is accepted if !full, or if full && rd_en on the same edge (simultaneous pop frees the slot).
- Push while full with no rd_en:
  - word dropped, overflow<=1;
  - last_data still updated;
  - ack still issued normally. The slave never stalls the master.
- Pop: rd_en && !empty advances the head. rd_en when empty is ignored with no state change.
- Simultaneous push and pop when not empty and not full: count unchanged.
- rd_data is the head word, valid whenever empty=0. It is updated the cycle after a pop, or the cycle after a push into an empty FIFO.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH. full = (count==DEPTH), empty = (count==0), all registered/consistent on the same cycle.
- clr_ovf clears overflow on the next edge. If a new overflow occurs on the same edge, set wins (overflow stays 1).

Test Plan:
1. Reset, then req=1 for 1 cycle with data_in=0xA5, DATA_W=8, ACK_CYCLES=2, FOUR_PHASE=0 -> ack high exactly 2 cycles starting the cycle after req, last_data=0xA5, count=1, rd_data=0xA5, empty=0.
2. DEPTH=4: push 0x11,0x22,0x33,0x44 then 0x55 with no reads -> full=1 after 4th, 5th transfer still acked, last_data=0x55, overflow=1, count=4; pops return 0x11..0x44 in order, then empty=1.
3. Full FIFO, next capture edge coincides with rd_en=1 -> 0x11 popped, new word 0x66 accepted, count stays 4, overflow unchanged; clr_ovf pulse -> overflow=0 unless a drop happens on the same edge (then stays 1).
4. FOUR_PHASE=1, ACK_CYCLES=2, req held 6 cycles with data 0x3C -> one capture only, ack stays high until the cycle after req sampled low, count=1.
5. FOUR_PHASE=0, req held high 7 cycles -> repeated captures (one per ack pulse + 1 idle cycle), count increments per capture, ack low for 1 cycle between pulses.
6. rst asserted in the 2nd ack cycle with count=3 -> ack=0, count=0, empty=1, last_data=0, overflow=0 next cycle; rd_en on empty produces no change.
